mux_2x1: RTL and testbench

Two-input, 32-bit-wide word selector for the single-cycle RISC-V datapath, used wherever one of two operands is chosen, e.g. ALU source B or PC source. The primary output is purely combinational so it fits in the single-cycle critical path. The block also provides a registered copy of the selected word and the select, clocked by the core clock, for pipeline-debug taps and trace capture.

---
 rtl/mux_2x1.sv | 37 +++
 tb/tb_mux_2x1.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1.sv
// Two-input word selector for the single-cycle datapath, with a registered
// copy of the selected word and select for debug taps and trace capture.
module mux_2x1 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] e1,
   input  logic [WIDTH-1:0] e2,
   input  logic             sel,
   input  logic             en,
   output logic [WIDTH-1:0] salMux,
   output logic [WIDTH-1:0] salMux_q,
   output logic             sel_q
);

   // An unknown select gives an unknown word instead of silently favouring an input
   always_comb begin
      salMux = 'x;
      if (sel == 1'b1)
         salMux = e2;
      else if (sel == 1'b0)
         salMux = e1;
   end

   // Trace registers hold the word alongside the select that chose it
   always_ff @(posedge clk) begin
      if (rst) begin
         salMux_q <= '0;
         sel_q    <= 1'b0;
      end else if (en) begin
         salMux_q <= salMux;
         sel_q    <= sel;
      end
   end

endmodule

// File: tb/tb_mux_2x1.sv
// Directed self-checking bench for mux_2x1: combinational select path and
// the registered trace copy under reset, capture, hold and back-to-back use.
module tb_mux_2x1;

   logic        clk;
   logic        rst;
   logic [31:0] e1;
   logic [31:0] e2;
   logic        sel;
   logic        en;
   logic [31:0] salMux;
   logic [31:0] salMux_q;
   logic        sel_q;
   logic        clkRun;
   int          vecCount;
   int          missCount;

   mux_2x1 #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .e1       (e1),
      .e2       (e2),
      .sel      (sel),
      .en       (en),
      .salMux   (salMux),
      .salMux_q (salMux_q),
      .sel_q    (sel_q)
   );

   // Clock stays parked low until the combinational-only checks are done
   initial clk = 1'b0;
   always begin
      #5;
      if (clkRun) clk = ~clk;
   end

   task automatic test_comb;
      e1 = 32'h0000_0001;
      e2 = 32'h0000_0002;
      sel = 1'b0;
      #10;
      vecCount++;
      if (salMux !== 32'h0000_0001) begin
         missCount++;
         $display("[TB] FAIL comb_sel0: got %h, expected %h", salMux, 32'h0000_0001);
      end
      sel = 1'b1;
      #10;
      vecCount++;
      if (salMux !== 32'h0000_0002) begin
         missCount++;
         $display("[TB] FAIL comb_sel1: got %h, expected %h", salMux, 32'h0000_0002);
      end
   endtask

   task automatic test_tracking;
      sel = 1'b0;
      e1 = 32'hDEAD_BEEF;
      #1;
      vecCount++;
      if (salMux !== 32'hDEAD_BEEF) begin
         missCount++;
         $display("[TB] FAIL track_e1_a: got %h, expected %h", salMux, 32'hDEAD_BEEF);
      end
      e1 = 32'h1234_5678;
      #1;
      vecCount++;
      if (salMux !== 32'h1234_5678) begin
         missCount++;
         $display("[TB] FAIL track_e1_b: got %h, expected %h", salMux, 32'h1234_5678);
      end
      e2 = 32'hCAFE_F00D;
      #1;
      vecCount++;
      if (salMux !== 32'h1234_5678) begin
         missCount++;
         $display("[TB] FAIL track_e2_ignored: got %h, expected %h", salMux, 32'h1234_5678);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      en = 1'b1;
      sel = 1'b1;
      e1 = 32'h1111_1111;
      e2 = 32'hFFFF_FFFF;
      #1;
      vecCount++;
      if (salMux !== 32'hFFFF_FFFF) begin
         missCount++;
         $display("[TB] FAIL reset_salMux_before: got %h, expected %h", salMux, 32'hFFFF_FFFF);
      end
      @(posedge clk);
      #1;
      vecCount++;
      if (salMux_q !== 32'h0000_0000) begin
         missCount++;
         $display("[TB] FAIL reset_salMux_q: got %h, expected %h", salMux_q, 32'h0);
      end
      vecCount++;
      if (sel_q !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL reset_sel_q: got %b, expected %b", sel_q, 1'b0);
      end
      vecCount++;
      if (salMux !== 32'hFFFF_FFFF) begin
         missCount++;
         $display("[TB] FAIL reset_salMux_after: got %h, expected %h", salMux, 32'hFFFF_FFFF);
      end
   endtask

   task automatic test_capture;
      @(negedge clk);
      rst = 1'b0;
      en = 1'b1;
      e1 = 32'hA5A5_A5A5;
      sel = 1'b0;
      @(posedge clk);
      #1;
      vecCount++;
      if (salMux_q !== 32'hA5A5_A5A5 || sel_q !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL capture_sel0: got %h/%b, expected %h/%b", salMux_q, sel_q, 32'hA5A5_A5A5, 1'b0);
      end
      @(negedge clk);
      sel = 1'b1;
      e2 = 32'h5A5A_5A5A;
      @(posedge clk);
      #1;
      vecCount++;
      if (salMux_q !== 32'h5A5A_5A5A || sel_q !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL capture_sel1: got %h/%b, expected %h/%b", salMux_q, sel_q, 32'h5A5A_5A5A, 1'b1);
      end
   endtask

   task automatic test_hold;
      logic [31:0] holdE1 [3];
      logic [31:0] holdE2 [3];
      logic        holdSel [3];
      logic [31:0] expMux;
      holdE1  = '{32'h0BAD_F00D, 32'h7777_0000, 32'h0000_0042};
      holdE2  = '{32'h1357_9BDF, 32'h0F0F_0F0F, 32'h8000_0001};
      holdSel = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en = 1'b0;
         e1 = holdE1[i];
         e2 = holdE2[i];
         sel = holdSel[i];
         expMux = holdSel[i] ? holdE2[i] : holdE1[i];
         #1;
         vecCount++;
         if (salMux !== expMux) begin
            missCount++;
            $display("[TB] FAIL hold_track[%0d]: got %h, expected %h", i, salMux, expMux);
         end
         @(posedge clk);
         #1;
         vecCount++;
         if (salMux_q !== 32'h5A5A_5A5A || sel_q !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL hold_regs[%0d]: got %h/%b, expected %h/%b", i, salMux_q, sel_q, 32'h5A5A_5A5A, 1'b1);
         end
      end
   endtask

   task automatic test_extremes;
      logic [31:0] prevMux;
      logic [31:0] expMux;
      e1 = 32'h0000_0000;
      e2 = 32'hFFFF_FFFF;
      sel = 1'b0;
      #1;
      prevMux = salMux;
      for (int i = 0; i < 6; i++) begin
         #4;
         sel = ~sel;
         expMux = sel ? 32'hFFFF_FFFF : 32'h0000_0000;
         #1;
         vecCount++;
         if (salMux !== expMux || (salMux ^ prevMux) !== 32'hFFFF_FFFF) begin
            missCount++;
            $display("[TB] FAIL extremes[%0d]: got %h (prev %h), expected %h", i, salMux, prevMux, expMux);
         end
         prevMux = salMux;
      end
   endtask

   // Consecutive captures, a mid-stream reset, and an input change between edges
   task automatic test_back_to_back;
      logic [31:0] bbE1 [4];
      logic [31:0] bbE2 [4];
      logic        bbSel [4];
      logic        bbRst [4];
      logic [31:0] expQ [4];
      logic        expSelQ [4];
      bbE1    = '{32'h0000_00FF, 32'h0101_0101, 32'h2468_ACE0, 32'h3C3C_3C3C};
      bbE2    = '{32'hFF00_0000, 32'h8888_8888, 32'h1111_2222, 32'hC3C3_C3C3};
      bbSel   = '{1'b1, 1'b0, 1'b1, 1'b1};
      bbRst   = '{1'b0, 1'b0, 1'b1, 1'b0};
      expQ    = '{32'hFF00_0000, 32'h0101_0101, 32'h0000_0000, 32'hC3C3_C3C3};
      expSelQ = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         en = 1'b1;
         rst = bbRst[i];
         e1 = bbE1[i];
         e2 = bbE2[i];
         sel = bbSel[i];
         @(posedge clk);
         #1;
         e1 = 32'hEEEE_EEEE;
         e2 = 32'hDDDD_DDDD;
         sel = ~bbSel[i];
         #1;
         vecCount++;
         if (salMux_q !== expQ[i] || sel_q !== expSelQ[i]) begin
            missCount++;
            $display("[TB] FAIL back_to_back[%0d]: got %h/%b, expected %h/%b", i, salMux_q, sel_q, expQ[i], expSelQ[i]);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      vecCount = 0;
      missCount = 0;
      clkRun = 1'b0;
      rst = 1'b0;
      en = 1'b0;
      e1 = '0;
      e2 = '0;
      sel = 1'b0;
      test_comb();
      test_tracking();
      clkRun = 1'b1;
      test_reset();
      test_capture();
      test_hold();
      test_extremes();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
